// File: rtl/core_pkg.sv
// Shared types and constants for the core top, drain engine and corelet.
// Instruction fields are bit positions inside the corelet instruction word.
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_HOLD,
    S_FIN
  } drainState_t;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  localparam int INST_ACC = 34;
  localparam int INST_LD  = 33;
  localparam int INST_XEN = 32;
  localparam int IMM_LO   = 0;

endpackage

// File: rtl/core_drain_ctrl.sv
// Drain engine: streams a psum memory range out over valid/ready and
// owns the psum port whenever it is not idle.
module core_drain_ctrl
  import core_pkg::*;
#(
  parameter int addr_w = 11,
  parameter int dw     = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              drainStart,
  input  logic [addr_w-1:0] drainBase,
  input  logic [addr_w:0]   drainLen,
  input  logic              outReady,
  input  logic              hostCen,
  input  logic              hostWen,
  input  logic [addr_w-1:0] hostAddr,
  input  logic [dw-1:0]     memQ,
  output logic              memCen,
  output logic              memWen,
  output logic [addr_w-1:0] memAddr,
  output logic              idle,
  output logic              busy,
  output logic              valid,
  output logic              done,
  output logic [dw-1:0]     drainData
);

  drainState_t       state;
  logic [addr_w-1:0] addr;
  logic [addr_w:0]   remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      done      <= 1'b0;
      drainData <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (drainStart) begin
            if (drainLen != '0) begin
              addr      <= drainBase;
              remaining <= drainLen;
              busy      <= 1'b1;
              state     <= S_READ;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_READ: state <= S_CAPT;
        S_CAPT: begin
          drainData <= memQ;
          valid     <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (outReady) begin
            valid     <= 1'b0;
            remaining <= remaining - (addr_w+1)'(1);
            addr      <= addr + addr_w'(1);
            state     <= (remaining == (addr_w+1)'(1)) ? S_FIN : S_READ;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    idle    = (state == S_IDLE);
    memCen  = hostCen;
    memWen  = hostWen;
    memAddr = hostAddr;
    if (!idle) begin
      memCen  = (state != S_READ);
      memWen  = 1'b1;
      memAddr = addr;
    end
  end

endmodule

// File: rtl/corelet.sv
// Simplified corelet datapath: per-lane immediate load, psum/sfp accumulate
// and activation injection, all combinational.
module corelet
  import core_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int inst_w  = 35
) (
  input  logic [inst_w-1:0]      inst,
  input  logic [bw*row-1:0]      xIn,
  input  logic [psum_bw*col-1:0] psumIn,
  input  logic [psum_bw*col-1:0] sfpIn,
  output logic [psum_bw*col-1:0] sfpOut
);

  logic [psum_bw-1:0] lane;
  logic [psum_bw-1:0] imm;

  // Even lanes take the low immediate half, odd lanes the high half.
  always_comb begin
    sfpOut = '0;
    lane   = '0;
    imm    = '0;
    for (int j = 0; j < col; j++) begin
      imm = (j % 2 == 0) ? psum_bw'(inst[IMM_LO +: 16])
                         : psum_bw'(inst[IMM_LO+16 +: 16]);
      lane = '0;
      if (inst[INST_LD])
        lane = lane + imm;
      if (inst[INST_ACC])
        lane = lane + psumIn[j*psum_bw +: psum_bw]
                    + sfpIn[j*psum_bw +: psum_bw];
      if (inst[INST_XEN])
        lane = lane + psum_bw'(xIn[(j%row)*bw +: bw]);
      sfpOut[j*psum_bw +: psum_bw] = lane;
    end
  end

endmodule

// File: rtl/sram.sv
// Single-port synchronous SRAM, active-low enables, one-cycle read.
// Q holds its value until the next read.
module sram #(
  parameter int width  = 32,
  parameter int addr_w = 11,
  parameter int num    = 2048
) (
  input  logic              clk,
  input  logic              cen,
  input  logic              wen,
  input  logic [addr_w-1:0] a,
  input  logic [width-1:0]  d,
  output logic [width-1:0]  q
);

  logic [width-1:0] mem [num];

  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) mem[a] <= d;
      else      q <= mem[a];
    end
  end

endmodule

// File: rtl/core_drain.sv
// Core top: corelet, xMem, psum memory, WS/OS mode register and the
// autonomous psum drain engine.
module core_drain
  import core_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11,
  parameter int num     = 2048,
  parameter int inst_w  = 35
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [inst_w-1:0]      inst,
  input  logic [bw*row-1:0]      D_xmem,
  input  logic                   x_cen,
  input  logic                   x_wen,
  input  logic [addr_w-1:0]      x_addr,
  input  logic                   p_cen,
  input  logic                   p_wen,
  input  logic [addr_w-1:0]      p_addr,
  input  logic                   mode_wr,
  input  logic                   mode_req,
  input  logic                   drain_start,
  input  logic [addr_w-1:0]      drain_base,
  input  logic [addr_w:0]        drain_len,
  input  logic                   out_ready,
  output logic                   mode,
  output logic                   busy,
  output logic                   err_mode,
  output logic                   valid,
  output logic [psum_bw*col-1:0] drain_data,
  output logic                   done,
  output logic [psum_bw*col-1:0] coreOut
);

  localparam int pw = psum_bw*col;

  logic [bw*row-1:0] xQ;
  logic [pw-1:0]     pQ;
  logic [pw-1:0]     psumIn;
  logic [pw-1:0]     sfpIn;
  logic              pCen;
  logic              pWen;
  logic [addr_w-1:0] pAddr;
  logic              idle;

  // Mode changes are only legal while the drain engine is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode     <= MODE_WS;
      err_mode <= 1'b0;
    end else if (mode_wr) begin
      if (idle) mode     <= mode_req;
      else      err_mode <= 1'b1;
    end
  end

  assign psumIn = (mode == MODE_OS) ? pQ : '0;
  assign sfpIn  = (mode == MODE_WS) ? pQ : '0;

  corelet #(
    .row(row), .col(col), .bw(bw),
    .psum_bw(psum_bw), .inst_w(inst_w)
  ) u_corelet (
    .inst   (inst),
    .xIn    (xQ),
    .psumIn (psumIn),
    .sfpIn  (sfpIn),
    .sfpOut (coreOut)
  );

  sram #(.width(bw*row), .addr_w(addr_w), .num(num)) u_xMem (
    .clk (clk),
    .cen (x_cen),
    .wen (x_wen),
    .a   (x_addr),
    .d   (D_xmem),
    .q   (xQ)
  );

  sram #(.width(pw), .addr_w(addr_w), .num(num)) u_psumMem (
    .clk (clk),
    .cen (pCen),
    .wen (pWen),
    .a   (pAddr),
    .d   (coreOut),
    .q   (pQ)
  );

  core_drain_ctrl #(.addr_w(addr_w), .dw(pw)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .drainStart (drain_start),
    .drainBase  (drain_base),
    .drainLen   (drain_len),
    .outReady   (out_ready),
    .hostCen    (p_cen),
    .hostWen    (p_wen),
    .hostAddr   (p_addr),
    .memQ       (pQ),
    .memCen     (pCen),
    .memWen     (pWen),
    .memAddr    (pAddr),
    .idle       (idle),
    .busy       (busy),
    .valid      (valid),
    .done       (done),
    .drainData  (drain_data)
  );

endmodule

// File: tb/tb_core_drain.sv
// Self-checking bench for core_drain: memory/queue model of expected beats
// plus directed timing and literal checks.
module tb_core_drain;
  import core_pkg::*;

  localparam int ROW = 8, COL = 8, BW = 4, PBW = 16;
  localparam int AW = 11, NUM = 2048, IW = 35;
  localparam int DW = PBW*COL;

  logic          clk = 0;
  logic          reset = 1;
  logic [IW-1:0] inst = '0;
  logic [BW*ROW-1:0] D_xmem = '0;
  logic          x_cen = 1, x_wen = 1;
  logic [AW-1:0] x_addr = '0;
  logic          p_cen = 1, p_wen = 1;
  logic [AW-1:0] p_addr = '0;
  logic          mode_wr = 0, mode_req = 0;
  logic          drain_start = 0;
  logic [AW-1:0] drain_base = '0;
  logic [AW:0]   drain_len = '0;
  logic          out_ready = 1;
  logic          mode, busy, err_mode, valid, done;
  logic [DW-1:0] drain_data, coreOut;

  core_drain #(
    .row(ROW), .col(COL), .bw(BW), .psum_bw(PBW),
    .addr_w(AW), .num(NUM), .inst_w(IW)
  ) dut (
    .clk(clk), .reset(reset), .inst(inst), .D_xmem(D_xmem),
    .x_cen(x_cen), .x_wen(x_wen), .x_addr(x_addr),
    .p_cen(p_cen), .p_wen(p_wen), .p_addr(p_addr),
    .mode_wr(mode_wr), .mode_req(mode_req),
    .drain_start(drain_start), .drain_base(drain_base),
    .drain_len(drain_len), .out_ready(out_ready),
    .mode(mode), .busy(busy), .err_mode(err_mode), .valid(valid),
    .drain_data(drain_data), .done(done), .coreOut(coreOut)
  );

  always #5 clk = ~clk;

  int passCnt = 0, totalCnt = 0;
  int cyc = 0;
  int startCyc = 0;
  logic [DW-1:0] memModel [NUM];
  logic [DW-1:0] expQ [$];
  logic [DW-1:0] gotQ [$];
  int rises [$];
  int doneCyc [$];
  logic prevV = 0, holdPend = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] laneFill(input logic [31:0] imm);
    logic [DW-1:0] v;
    v = '0;
    for (int j = 0; j < COL; j++)
      v[j*PBW +: PBW] = (j % 2 == 0) ? imm[15:0] : imm[31:16];
    return v;
  endfunction

  // Sink-side checker: every beat must match the model queue in order.
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
      holdPend = 0;
      prevV = 0;
    end else begin
      if (holdPend) chk("valid held until ready", valid, 1);
      if (valid) begin
        if (!prevV) rises.push_back(cyc);
        if (expQ.size() == 0) chk("beat while none expected", valid, 0);
        else begin
          chk("drain_data", drain_data, expQ[0]);
          if (out_ready) begin
            gotQ.push_back(drain_data);
            void'(expQ.pop_front());
          end
        end
      end
      if (done) begin
        doneCyc.push_back(cyc);
        chk("done after all beats", expQ.size(), 0);
      end
      holdPend = valid && !out_ready;
      prevV = valid;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic hostWrite(input int a, input logic [31:0] imm);
    inst = '0;
    inst[INST_LD] = 1'b1;
    inst[31:0] = imm;
    p_cen = 0; p_wen = 0; p_addr = AW'(a);
    memModel[a] = laneFill(imm);
    step();
    p_cen = 1; p_wen = 1; inst = '0;
  endtask

  task automatic startDrain(input int base, input int len, input bit take);
    drain_base = AW'(base);
    drain_len = (AW+1)'(len);
    drain_start = 1;
    startCyc = cyc;
    if (take)
      for (int i = 0; i < len; i++)
        expQ.push_back(memModel[(base+i) % NUM]);
    step();
    drain_start = 0;
  endtask

  task automatic clearLog();
    rises.delete(); doneCyc.delete(); gotQ.delete();
  endtask

  task automatic waitDone(input string nm, output int dc);
    int n;
    n = 0;
    while (doneCyc.size() == 0 && n < 200) begin step(); n++; end
    chk({nm, " done seen"}, doneCyc.size(), 1);
    dc = (doneCyc.size() > 0) ? doneCyc[0] : -1000;
  endtask

  int s, dc, seen;
  logic pv;

  initial begin
    // Reset state
    step(3);
    reset = 0;
    step();
    chk("reset mode", mode, 0);
    chk("reset busy", busy, 0);
    chk("reset err_mode", err_mode, 0);
    chk("reset valid", valid, 0);
    chk("reset done", done, 0);
    chk("reset drain_data", drain_data, 0);

    // Mode write in IDLE
    mode_wr = 1; mode_req = 1;
    step();
    mode_wr = 0;
    chk("mode set in idle", mode, 1);
    chk("no err in idle", err_mode, 0);

    // Load psum words and pin coreOut encoding
    inst = '0; inst[INST_LD] = 1'b1; inst[31:0] = 32'h11111111;
    #1;
    chk("coreOut imm literal", coreOut, 128'h11111111111111111111111111111111);
    hostWrite(5, 32'h11111111);
    hostWrite(6, 32'h22222222);
    hostWrite(7, 32'h33333333);
    hostWrite(8, 32'h44444444);

    // Basic drain, with an illegal mode write while busy
    clearLog();
    startDrain(5, 4, 1);
    s = startCyc;
    mode_wr = 1; mode_req = 0;
    step();
    mode_wr = 0;
    chk("mode held during drain", mode, 1);
    chk("err_mode set", err_mode, 1);
    waitDone("basic", dc);
    chk("basic beats", gotQ.size(), 4);
    chk("first valid latency", (rises.size() > 0) ? rises[0] - s : -1, 3);
    for (int i = 1; i < 4; i++)
      chk("beat spacing",
          (rises.size() > i) ? rises[i] - rises[i-1] : -1, 3);
    chk("basic done cycle", dc - s, 14);
    chk("beat0 literal", (gotQ.size() > 0) ? gotQ[0] : '0,
        128'h11111111111111111111111111111111);
    chk("beat3 literal", (gotQ.size() > 3) ? gotQ[3] : '0,
        128'h44444444444444444444444444444444);
    chk("busy after done", busy, 0);
    chk("err_mode sticky", err_mode, 1);

    // Backpressure on beat 2
    clearLog();
    startDrain(5, 4, 1);
    s = startCyc;
    seen = 0; pv = 0;
    for (int n = 0; n < 100 && seen < 2; n++) begin
      if (valid && !pv) seen++;
      pv = valid;
      if (seen < 2) step();
    end
    out_ready = 0;
    step(5);
    chk("stalled data literal", drain_data,
        128'h22222222222222222222222222222222);
    out_ready = 1;
    waitDone("stall", dc);
    chk("stall beats", gotQ.size(), 4);
    chk("stall done cycle", dc - s, 19);
    chk("stall beat1 literal", (gotQ.size() > 1) ? gotQ[1] : '0,
        128'h22222222222222222222222222222222);

    // Address wrap
    hostWrite(2046, 32'hAAAA5555);
    hostWrite(2047, 32'h0F0FF0F0);
    hostWrite(0, 32'h12345678);
    hostWrite(1, 32'h9ABCDEF0);
    clearLog();
    startDrain(2046, 4, 1);
    waitDone("wrap", dc);
    chk("wrap beats", gotQ.size(), 4);
    chk("wrap beat0 literal", (gotQ.size() > 0) ? gotQ[0] : '0,
        128'hAAAA5555AAAA5555AAAA5555AAAA5555);
    chk("wrap beat2 literal", (gotQ.size() > 2) ? gotQ[2] : '0,
        128'h12345678123456781234567812345678);
    chk("wrap beat3 literal", (gotQ.size() > 3) ? gotQ[3] : '0,
        128'h9ABCDEF09ABCDEF09ABCDEF09ABCDEF0);

    // Zero-length drain
    clearLog();
    startDrain(0, 0, 1);
    s = startCyc;
    waitDone("len0", dc);
    chk("len0 done cycle", dc - s, 2);
    chk("len0 no beats", gotQ.size(), 0);

    // drain_start while busy is ignored
    clearLog();
    startDrain(5, 2, 1);
    s = startCyc;
    step(2);
    startDrain(0, 3, 0);
    waitDone("busy-start", dc);
    chk("busy-start done cycle", dc - s, 8);
    step(12);
    chk("busy-start beats", gotQ.size(), 2);
    chk("busy-start single done", doneCyc.size(), 1);
    chk("busy-start idle", busy, 0);

    // Activation path through xMem
    D_xmem = 32'h76543210; x_addr = 3; x_cen = 0; x_wen = 0;
    step();
    x_wen = 1;
    step();
    x_cen = 1;
    inst = '0; inst[INST_XEN] = 1'b1;
    #1;
    chk("xmem lanes", coreOut, 128'h00070006000500040003000200010000);
    inst = '0;

    // Reset while holding a beat
    clearLog();
    out_ready = 0;
    startDrain(7, 2, 1);
    step(4);
    chk("hold valid before reset", valid, 1);
    chk("hold busy before reset", busy, 1);
    reset = 1;
    step();
    chk("reset-abort valid", valid, 0);
    chk("reset-abort busy", busy, 0);
    chk("reset-abort done", done, 0);
    chk("reset-abort mode", mode, 0);
    chk("reset-abort err_mode", err_mode, 0);
    reset = 0;
    out_ready = 1;
    inst = '0; inst[INST_ACC] = 1'b1;
    p_cen = 0; p_wen = 1; p_addr = 7;
    step();
    p_cen = 1;
    chk("host read WS", coreOut, memModel[7]);
    inst[INST_LD] = 1'b1; inst[31:0] = 32'h00010001;
    #1;
    chk("acc+imm literal", coreOut, 128'h33343334333433343334333433343334);
    mode_wr = 1; mode_req = 1;
    step();
    mode_wr = 0;
    chk("acc+imm OS literal", coreOut,
        128'h33343334333433343334333433343334);
    inst = '0;
    step(4);
    chk("no done after abort", doneCyc.size(), 0);
    chk("model drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("%0d/%0d checks passed", passCnt, totalCnt + 1);
    $fatal(1);
  end

endmodule
